// File: rtl/i2c_reg_write16_pkg.sv
// Shared definitions for the I2C register-write engine: state encoding and
// transaction framing constants used by the engine, the config sequencer and the bench.
package i2c_reg_write16_pkg;

    localparam int NBYTES        = 3;
    localparam int BITS_PER_BYTE = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT_L,
        S_BIT_H,
        S_STOP_L,
        S_STOP_H,
        S_STOP_REL,
        S_DONE
    } state_e;

endpackage

// File: rtl/i2c_reg_write16.sv
// Single-shot I2C master write: START, {addr,W}, reg byte, value byte, STOP.
// clk2 runs at twice the SCL rate; enable doubles as the asynchronous active-low reset.
module i2c_reg_write16
    import i2c_reg_write16_pkg::*;
#(
    parameter int NBYTES = i2c_reg_write16_pkg::NBYTES
) (
    input  logic              clk2,
    input  logic              enable,
    input  logic [6:0]        addr,
    input  logic [15:0]       data,
    output logic              done,
    output logic [NBYTES-1:0] nack,
    inout  wire               sda,
    inout  wire               scl
);

    localparam int         SHIFT_W   = 8 * NBYTES;
    localparam logic [3:0] LAST_BIT  = 4'(BITS_PER_BYTE - 1);
    localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

    state_e              state_q, state_d;
    logic [SHIFT_W-1:0]  shreg_q, shreg_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [NBYTES-1:0]   nack_q, nack_d;
    logic                done_q, done_d;
    logic                scl_low_q, scl_low_d;
    logic                sda_low_q, sda_low_d;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        nack_d     = nack_q;
        done_d     = done_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_START;
                shreg_d = {addr, 1'b0, data};
            end
            S_START:  state_d = S_BIT_L;
            S_BIT_L:  state_d = S_BIT_H;
            S_BIT_H: begin
                // A slave holding scl low keeps us here (clock stretching).
                if (scl == 1'b1) begin
                    state_d = S_BIT_L;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (sda == 1'b1) nack_d[LAST_BYTE - byte_cnt_q] = 1'b1;
                        bit_cnt_d = '0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            state_d    = S_STOP_L;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shreg_d   = {shreg_q[SHIFT_W-2:0], 1'b0};
                    end
                end
            end
            S_STOP_L:   state_d = S_STOP_H;
            S_STOP_H:   state_d = S_STOP_REL;
            S_STOP_REL: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE:     state_d = S_DONE;
            default:    state_d = S_IDLE;
        endcase
        scl_low_d = (state_d == S_BIT_L) || (state_d == S_STOP_L);
    end

    always_ff @(posedge clk2 or negedge enable) begin
        if (!enable) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            nack_q     <= '0;
            done_q     <= 1'b0;
            scl_low_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            scl_low_q  <= scl_low_d;
        end
    end

    // SDA moves only on the falling clk2 edge, i.e. mid-way through a low SCL phase.
    always_comb begin
        sda_low_d = sda_low_q;
        unique case (state_q)
            S_START, S_STOP_L:          sda_low_d = 1'b1;
            S_BIT_L:                    sda_low_d = (bit_cnt_q != LAST_BIT) && !shreg_q[SHIFT_W-1];
            S_IDLE, S_STOP_REL, S_DONE: sda_low_d = 1'b0;
            default:                    sda_low_d = sda_low_q;
        endcase
    end

    always_ff @(negedge clk2 or negedge enable) begin
        if (!enable) sda_low_q <= 1'b0;
        else         sda_low_q <= sda_low_d;
    end

    assign scl  = scl_low_q ? 1'b0 : 1'bz;
    assign sda  = sda_low_q ? 1'b0 : 1'bz;
    assign done = done_q;
    assign nack = nack_q;

endmodule

// File: tb/tb_i2c_reg_write16.sv
// Bench for i2c_reg_write16 with a behavioural I2C slave on pulled-up open-drain lines.
module tb_i2c_reg_write16;

    logic        clk2 = 1'b0;
    logic        enable = 1'b0;
    logic [6:0]  addr = '0;
    logic [15:0] data = '0;
    logic        done;
    logic [2:0]  nack;
    wire         sda_w;
    wire         scl_w;

    always #5 clk2 = ~clk2;

    i2c_reg_write16 dut (
        .clk2   (clk2),
        .enable (enable),
        .addr   (addr),
        .data   (data),
        .done   (done),
        .nack   (nack),
        .sda    (sda_w),
        .scl    (scl_w)
    );

    pullup (sda_w);
    pullup (scl_w);

    // ---------------- slave model ----------------
    logic       slv_sda_low = 1'b0;
    logic       slv_scl_low = 1'b0;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;
    assign scl_w = slv_scl_low ? 1'b0 : 1'bz;

    logic [2:0] nak_cfg = 3'b000;   // bit 2 = address byte, as in nack
    int         stretch_bit = -1;   // index of bit whose low phase gets stretched
    int         start_cnt = 0, stop_cnt = 0, edge_cnt = 0;
    int         fall_cnt = 0, rise_cnt = 0;
    logic [7:0] sh = '0;
    logic [7:0] rx_q[$];
    logic       p_sda = 1'b1, p_scl = 1'b1;
    event       stretch_ev;

    always @(sda_w or scl_w) begin
        if (p_scl === 1'b1 && scl_w === 1'b1 && p_sda === 1'b1 && sda_w === 1'b0) begin
            start_cnt++;
            fall_cnt = 0;
            rise_cnt = 0;
            rx_q.delete();
        end else if (p_scl === 1'b1 && scl_w === 1'b1 && p_sda === 1'b0 && sda_w === 1'b1) begin
            stop_cnt++;
        end
        if (p_scl === 1'b1 && scl_w === 1'b0) begin
            if (fall_cnt < 27 && fall_cnt % 9 == 8) slv_sda_low = !nak_cfg[2 - fall_cnt / 9];
            else                                    slv_sda_low = 1'b0;
            if (fall_cnt == stretch_bit) -> stretch_ev;
            fall_cnt++;
        end
        if (p_scl === 1'b0 && scl_w === 1'b1) begin
            if (rise_cnt < 27 && rise_cnt % 9 < 8) begin
                sh = {sh[6:0], sda_w};
                if (rise_cnt % 9 == 7) rx_q.push_back(sh);
            end
            rise_cnt++;
        end
        if (p_sda !== sda_w || p_scl !== scl_w) edge_cnt++;
        p_sda = sda_w;
        p_scl = scl_w;
    end

    always @(stretch_ev) begin
        slv_scl_low = 1'b1;
        repeat (6) @(posedge clk2);
        #1 slv_scl_low = 1'b0;
    end

    // ---------------- scoreboard / stimulus ----------------
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    task automatic drive_txn(input logic [6:0] a, input logic [15:0] d, input logic [2:0] nak,
                             input int stretch, input int chg_at, input int abort_at,
                             output int lat, output int ns, output int np);
        int s0, p0;
        @(negedge clk2);
        enable      = 1'b0;
        addr        = a;
        data        = d;
        nak_cfg     = nak;
        stretch_bit = stretch;
        exp_q.push_back({a, 1'b0});
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        @(negedge clk2);
        s0 = start_cnt;
        p0 = stop_cnt;
        enable = 1'b1;
        lat = 0;
        while (done !== 1'b1 && lat < 400) begin
            @(posedge clk2);
            #1;
            lat++;
            if (lat == chg_at) begin
                data = d ^ 16'hffff;
                addr = a ^ 7'h7f;
            end
            if (lat == abort_at) begin
                @(negedge clk2);
                #1 enable = 1'b0;
                #1;
                break;
            end
        end
        if (done !== 1'b1 && abort_at == 0) lat = -1;
        ns = start_cnt - s0;
        np = stop_cnt - p0;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        addr   = 7'h39;
        data   = 16'h4110;
        repeat (3) @(posedge clk2);
        #1;
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (nack !== 3'b000)  begin errors++; $display("FAIL reset_nack got=%b exp=000", nack); end
        checks++; if (scl_w !== 1'b1)   begin errors++; $display("FAIL reset_scl got=%b exp=1", scl_w); end
        checks++; if (sda_w !== 1'b1)   begin errors++; $display("FAIL reset_sda got=%b exp=1", sda_w); end
    endtask

    task automatic test_basic();
        int lat, ns, np;
        logic [7:0] e;
        drive_txn(7'h39, 16'h4110, 3'b000, -1, 0, 0, lat, ns, np);
        checks++; if (lat != 59)       begin errors++; $display("FAIL basic_latency got=%0d exp=59", lat); end
        checks++; if (nack !== 3'b000) begin errors++; $display("FAIL basic_nack got=%b exp=000", nack); end
        checks++; if (ns != 1 || np != 1) begin errors++; $display("FAIL basic_start_stop got=%0d/%0d exp=1/1", ns, np); end
        checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL basic_nbytes got=%0d exp=3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== e) begin
                errors++;
                $display("FAIL basic_byte%0d got=%h exp=%h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, e);
            end
        end
    endtask

    task automatic test_nack_addr();
        int lat, ns, np;
        logic [7:0] e;
        drive_txn(7'h39, 16'h4110, 3'b100, -1, 0, 0, lat, ns, np);
        checks++; if (done !== 1'b1)   begin errors++; $display("FAIL nack_done got=%b exp=1", done); end
        checks++; if (nack !== 3'b100) begin errors++; $display("FAIL nack_flags got=%b exp=100", nack); end
        checks++; if (np != 1)         begin errors++; $display("FAIL nack_stop got=%0d exp=1", np); end
        checks++; if (lat != 59)       begin errors++; $display("FAIL nack_latency got=%0d exp=59", lat); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== e) begin
                errors++;
                $display("FAIL nack_byte%0d got=%h exp=%h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, e);
            end
        end
    endtask

    task automatic test_stretch();
        int lat, ns, np;
        logic [7:0] e;
        drive_txn(7'h39, 16'h4110, 3'b000, 10, 0, 0, lat, ns, np);
        checks++; if (lat != 59 + 5)   begin errors++; $display("FAIL stretch_latency got=%0d exp=64", lat); end
        checks++; if (nack !== 3'b000) begin errors++; $display("FAIL stretch_nack got=%b exp=000", nack); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== e) begin
                errors++;
                $display("FAIL stretch_byte%0d got=%h exp=%h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, e);
            end
        end
    endtask

    task automatic test_abort();
        int lat, ns, np;
        logic [7:0] e;
        drive_txn(7'h39, 16'h4110, 3'b000, -1, 0, 20, lat, ns, np);
        exp_q.delete();
        checks++; if (scl_w !== 1'b1)  begin errors++; $display("FAIL abort_scl got=%b exp=1", scl_w); end
        checks++; if (sda_w !== 1'b1)  begin errors++; $display("FAIL abort_sda got=%b exp=1", sda_w); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (nack !== 3'b000) begin errors++; $display("FAIL abort_nack got=%b exp=000", nack); end
        drive_txn(7'h39, 16'h4110, 3'b000, -1, 0, 0, lat, ns, np);
        checks++; if (lat != 59)       begin errors++; $display("FAIL abort_retry_latency got=%0d exp=59", lat); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== e) begin
                errors++;
                $display("FAIL abort_retry_byte%0d got=%h exp=%h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, ns, np, e0;
        logic [7:0] e;
        e0 = edge_cnt;
        repeat (100) @(posedge clk2);
        #1;
        checks++; if (edge_cnt != e0) begin errors++; $display("FAIL hold_bus_quiet got=%0d exp=0 edges", edge_cnt - e0); end
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL hold_done got=%b exp=1", done); end
        drive_txn(7'h39, 16'h9803, 3'b000, -1, 0, 0, lat, ns, np);
        checks++; if (lat != 59)      begin errors++; $display("FAIL b2b_latency got=%0d exp=59", lat); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== e) begin
                errors++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, e);
            end
        end
    endtask

    task automatic test_input_change();
        int lat, ns, np;
        logic [7:0] e;
        drive_txn(7'h2a, 16'h5ac3, 3'b000, -1, 4, 0, lat, ns, np);
        checks++; if (lat != 59) begin errors++; $display("FAIL latch_latency got=%0d exp=59", lat); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== e) begin
                errors++;
                $display("FAIL latch_byte%0d got=%h exp=%h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nack_addr();
        test_stretch();
        test_abort();
        test_back_to_back();
        test_input_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
